// File: rtl/adc_scan_pkg.sv
// adc_scan_pkg: shared constants, the sequencer state encoding, and a
// lowest-set-channel helper used by the scan sequencer and its
// next-channel picker.
package adc_scan_pkg;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;
    localparam int DATA_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SELECT  = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_CONVERT = 3'd3,
        ST_WAIT_HI = 3'd4,
        ST_WAIT_LO = 3'd5,
        ST_OUTPUT  = 3'd6
    } scan_state_t;

    // Lowest enabled channel in a mask; returns 0 for an empty mask.
    function automatic logic [CH_W-1:0] lowest_set_ch(input logic [NUM_CH-1:0] mask);
        logic [CH_W-1:0] ch;
        ch = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i]) ch = CH_W'(i);
        end
        return ch;
    endfunction

endpackage

// File: rtl/adc_scan_sequencer_if.sv
// adc_scan_sequencer_if: control strobes from the DSP decode, the ADC and
// analog-mux handshake, and the downstream sample valid/ready channel.
interface adc_scan_sequencer_if;
    import adc_scan_pkg::*;

    logic                scan_start;
    logic                scan_abort;
    logic [NUM_CH-1:0]   ch_mask;
    logic                continuous;
    logic                adc_busy;
    logic [DATA_W-1:0]   adc_data;
    logic                samp_ready;
    logic                mux_ctrl;
    logic [CH_W-1:0]     adc_data_choice;
    logic                adc_conv;
    logic [DATA_W-1:0]   samp_data;
    logic [CH_W-1:0]     samp_ch;
    logic                samp_valid;
    logic                scan_busy;
    logic                scan_done;
    logic                conv_err;

    // Environment side: DSP control, ADC model, downstream consumer.
    modport master (
        output scan_start, scan_abort, ch_mask, continuous,
        output adc_busy, adc_data, samp_ready,
        input  mux_ctrl, adc_data_choice, adc_conv,
        input  samp_data, samp_ch, samp_valid,
        input  scan_busy, scan_done, conv_err
    );

    // Sequencer side.
    modport slave (
        input  scan_start, scan_abort, ch_mask, continuous,
        input  adc_busy, adc_data, samp_ready,
        output mux_ctrl, adc_data_choice, adc_conv,
        output samp_data, samp_ch, samp_valid,
        output scan_busy, scan_done, conv_err
    );

endinterface

// File: rtl/adc_scan_sequencer_next_channel.sv
// adc_next_channel: picks the next enabled channel above the current one;
// when none is left it returns the lowest enabled channel and flags a wrap.
module adc_next_channel
    import adc_scan_pkg::*;
(
    input  logic [NUM_CH-1:0] mask_i,
    input  logic [CH_W-1:0]   cur_i,
    output logic [CH_W-1:0]   nxt_o,
    output logic              wrap_o
);

    // Search downward so the closest enabled channel above cur_i wins.
    always_comb begin
        nxt_o  = lowest_set_ch(mask_i);
        wrap_o = 1'b1;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask_i[i] && (i > int'(cur_i))) begin
                nxt_o  = CH_W'(i);
                wrap_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/adc_scan_sequencer.sv
// adc_scan_sequencer: walks the enabled ADC channels, settles the analog
// mux, fires one conversion per channel and hands each result downstream.
// Optional conversion watchdog enabled by defining ADC_SCAN_TIMEOUT_EN.
module adc_scan_sequencer #(
    parameter int unsigned SETTLE_CYCLES  = 64,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                 dsp_clkout,
    input  logic                 reset,
    adc_scan_sequencer_if.slave  bus
);
    import adc_scan_pkg::*;

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 65535 ||
        TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
        $error("adc_scan_sequencer: SETTLE_CYCLES/TIMEOUT_CYCLES out of 1..65535");
    end

    scan_state_t         state_q;
    logic [NUM_CH-1:0]   mask_q;
    logic                cont_q;
    logic [CH_W-1:0]     ch_q;
    logic [15:0]         settle_cnt_q;
    logic                mux_ctrl_q;
    logic [CH_W-1:0]     choice_q;
    logic                adc_conv_q;
    logic [DATA_W-1:0]   samp_data_q;
    logic [CH_W-1:0]     samp_ch_q;
    logic                samp_valid_q;
    logic                scan_busy_q;
    logic                scan_done_q;
    logic [CH_W-1:0]     next_ch;
    logic                next_wrap;

`ifdef ADC_SCAN_TIMEOUT_EN
    localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0]         wdog_q;
    logic                conv_err_q;
`endif

    adc_next_channel u_next_channel (
        .mask_i (mask_q),
        .cur_i  (ch_q),
        .nxt_o  (next_ch),
        .wrap_o (next_wrap)
    );

    // Scan FSM: abort wins over everything; the watchdog overrides capture.
    always_ff @(posedge dsp_clkout or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            mask_q       <= '0;
            cont_q       <= 1'b0;
            ch_q         <= '0;
            settle_cnt_q <= '0;
            mux_ctrl_q   <= 1'b0;
            choice_q     <= '0;
            adc_conv_q   <= 1'b0;
            samp_data_q  <= '0;
            samp_ch_q    <= '0;
            samp_valid_q <= 1'b0;
            scan_busy_q  <= 1'b0;
            scan_done_q  <= 1'b0;
`ifdef ADC_SCAN_TIMEOUT_EN
            wdog_q       <= '0;
            conv_err_q   <= 1'b0;
`endif
        end else begin
            adc_conv_q  <= 1'b0;
            scan_done_q <= 1'b0;
            if (bus.scan_abort) begin
                state_q      <= ST_IDLE;
                mux_ctrl_q   <= 1'b0;
                samp_valid_q <= 1'b0;
                scan_busy_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (bus.scan_start && (bus.ch_mask != '0)) begin
                            state_q     <= ST_SELECT;
                            mask_q      <= bus.ch_mask;
                            cont_q      <= bus.continuous;
                            ch_q        <= lowest_set_ch(bus.ch_mask);
                            scan_busy_q <= 1'b1;
`ifdef ADC_SCAN_TIMEOUT_EN
                            conv_err_q  <= 1'b0;
`endif
                        end
                    end
                    ST_SELECT: begin
                        choice_q     <= ch_q;
                        mux_ctrl_q   <= 1'b1;
                        settle_cnt_q <= 16'(SETTLE_CYCLES);
                        state_q      <= ST_SETTLE;
                    end
                    ST_SETTLE: begin
                        if (settle_cnt_q == '0) begin
                            state_q    <= ST_CONVERT;
                            adc_conv_q <= 1'b1;
`ifdef ADC_SCAN_TIMEOUT_EN
                            wdog_q     <= '0;
`endif
                        end else begin
                            settle_cnt_q <= settle_cnt_q - 16'd1;
                        end
                    end
                    ST_CONVERT: begin
                        state_q <= ST_WAIT_HI;
                    end
                    ST_WAIT_HI: begin
                        if (bus.adc_busy) state_q <= ST_WAIT_LO;
                    end
                    ST_WAIT_LO: begin
                        if (!bus.adc_busy) begin
                            samp_data_q  <= bus.adc_data;
                            samp_ch_q    <= ch_q;
                            samp_valid_q <= 1'b1;
                            state_q      <= ST_OUTPUT;
                        end
                    end
                    ST_OUTPUT: begin
                        if (bus.samp_ready) begin
                            samp_valid_q <= 1'b0;
                            ch_q         <= next_ch;
                            if (!next_wrap || cont_q) begin
                                state_q <= ST_SELECT;
                            end else begin
                                state_q     <= ST_IDLE;
                                scan_done_q <= 1'b1;
                                mux_ctrl_q  <= 1'b0;
                                scan_busy_q <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
`ifdef ADC_SCAN_TIMEOUT_EN
                if (state_q == ST_CONVERT || state_q == ST_WAIT_HI || state_q == ST_WAIT_LO) begin
                    if (wdog_q == WDOG_LAST) begin
                        state_q      <= ST_IDLE;
                        mux_ctrl_q   <= 1'b0;
                        samp_valid_q <= 1'b0;
                        scan_busy_q  <= 1'b0;
                        conv_err_q   <= 1'b1;
                    end else begin
                        wdog_q <= wdog_q + 16'd1;
                    end
                end
`endif
            end
        end
    end

    assign bus.mux_ctrl        = mux_ctrl_q;
    assign bus.adc_data_choice = choice_q;
    assign bus.adc_conv        = adc_conv_q;
    assign bus.samp_data       = samp_data_q;
    assign bus.samp_ch         = samp_ch_q;
    assign bus.samp_valid      = samp_valid_q;
    assign bus.scan_busy       = scan_busy_q;
    assign bus.scan_done       = scan_done_q;
`ifdef ADC_SCAN_TIMEOUT_EN
    assign bus.conv_err        = conv_err_q;
`else
    assign bus.conv_err        = 1'b0;
`endif

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// tb_adc_scan_sequencer: directed bench for adc_scan_sequencer with
// SETTLE_CYCLES = 4, TIMEOUT_CYCLES = 16 and a 3-cycle ADC busy model.
// Timeout expectations follow ADC_SCAN_TIMEOUT_EN.
module tb_adc_scan_sequencer;

    logic dsp_clkout;
    logic reset;
    int   vectors     = 0;
    int   miscompares = 0;
    int   adcMode     = 0;
    logic [15:0] adcDataBase = 16'h0000;

    adc_scan_sequencer_if bus ();

    adc_scan_sequencer #(
        .SETTLE_CYCLES  (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .dsp_clkout (dsp_clkout),
        .reset      (reset),
        .bus        (bus)
    );

    // Free-running 10-time-unit clock
    initial begin
        dsp_clkout = 1'b0;
        forever #5 dsp_clkout = ~dsp_clkout;
    end

    // ADC model: on a conversion pulse, busy for 3 clocks, data = base + channel
    initial begin
        bus.adc_busy = 1'b0;
        bus.adc_data = 16'h0000;
        forever begin
            @(posedge dsp_clkout);
            #1;
            if (bus.adc_conv === 1'b1 && adcMode == 0) begin
                bus.adc_busy = 1'b1;
                bus.adc_data = adcDataBase + 16'(bus.adc_data_choice);
                repeat (3) @(posedge dsp_clkout);
                #1;
                bus.adc_busy = 1'b0;
            end
        end
    end

    // Hard stop in case something wedges outside the bounded waits
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: observed no finish, expected finish before 200000");
        $fatal(1, "[TB] simulation time limit reached");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Pulses scan_start for one cycle; returns at the negedge after the sampling edge
    task automatic applyStimulus(input logic [3:0] mask, input logic cont);
        @(negedge dsp_clkout);
        bus.ch_mask    = mask;
        bus.continuous = cont;
        bus.scan_start = 1'b1;
        @(negedge dsp_clkout);
        bus.scan_start = 1'b0;
    endtask

    task automatic waitValid(input string tag, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge dsp_clkout);
            if (bus.samp_valid === 1'b1) seen = 1'b1;
        end
        checkOutput(tag, {31'b0, seen}, 32'd1);
    endtask

    task automatic waitConv(input string tag, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge dsp_clkout);
            if (bus.adc_conv === 1'b1) seen = 1'b1;
        end
        checkOutput(tag, {31'b0, seen}, 32'd1);
    endtask

    // Directed sequence
    initial begin
        logic [1:0] expCh;
        bit stableOk;

        reset          = 1'b1;
        bus.scan_start = 1'b0;
        bus.scan_abort = 1'b0;
        bus.ch_mask    = 4'b0000;
        bus.continuous = 1'b0;
        bus.samp_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge dsp_clkout);
        checkOutput("rst_mux",    bus.mux_ctrl,        0);
        checkOutput("rst_choice", bus.adc_data_choice, 0);
        checkOutput("rst_conv",   bus.adc_conv,        0);
        checkOutput("rst_valid",  bus.samp_valid,      0);
        checkOutput("rst_data",   bus.samp_data,       0);
        checkOutput("rst_busy",   bus.scan_busy,       0);
        checkOutput("rst_done",   bus.scan_done,       0);
        checkOutput("rst_err",    bus.conv_err,        0);
        reset = 1'b0;

        // Single pass over all four channels with start-latency checks
        adcDataBase = 16'h1100;
        applyStimulus(4'b1111, 1'b0);
        checkOutput("t1_busy_after_start", bus.scan_busy, 1);
        checkOutput("t1_mux_before_select", bus.mux_ctrl, 0);
        @(negedge dsp_clkout);
        checkOutput("t1_mux_after_select", bus.mux_ctrl, 1);
        checkOutput("t1_choice_first", bus.adc_data_choice, 0);
        repeat (4) @(negedge dsp_clkout);
        checkOutput("t1_conv_not_early", bus.adc_conv, 0);
        @(negedge dsp_clkout);
        checkOutput("t1_conv_on_time", bus.adc_conv, 1);
        @(negedge dsp_clkout);
        checkOutput("t1_conv_one_cycle", bus.adc_conv, 0);
        for (int ch = 0; ch < 4; ch++) begin
            waitValid("t1_valid", 40);
            checkOutput("t1_samp_ch",   bus.samp_ch,   ch);
            checkOutput("t1_samp_data", bus.samp_data, 32'h1100 + ch);
            @(negedge dsp_clkout);
            if (ch < 3) begin
                checkOutput("t1_valid_drop", bus.samp_valid, 0);
                checkOutput("t1_no_done_mid", bus.scan_done, 0);
                @(negedge dsp_clkout);
                checkOutput("t1_next_choice", bus.adc_data_choice, ch + 1);
            end else begin
                checkOutput("t1_done_pulse", bus.scan_done,  1);
                checkOutput("t1_mux_off",    bus.mux_ctrl,   0);
                checkOutput("t1_idle_busy",  bus.scan_busy,  0);
                checkOutput("t1_idle_valid", bus.samp_valid, 0);
                @(negedge dsp_clkout);
                checkOutput("t1_done_once",  bus.scan_done,  0);
                checkOutput("t1_choice_hold", bus.adc_data_choice, 3);
            end
        end

        // Sparse mask, continuous: 1,3,1,3,1 then abort
        adcDataBase = 16'h2200;
        applyStimulus(4'b1010, 1'b1);
        for (int k = 0; k < 5; k++) begin
            expCh = (k % 2 == 0) ? 2'd1 : 2'd3;
            waitValid("t2_valid", 40);
            checkOutput("t2_samp_ch",   bus.samp_ch,   expCh);
            checkOutput("t2_samp_data", bus.samp_data, 32'h2200 + expCh);
        end
        @(negedge dsp_clkout);
        bus.scan_abort = 1'b1;
        @(negedge dsp_clkout);
        bus.scan_abort = 1'b0;
        checkOutput("t2_abort_busy",  bus.scan_busy,  0);
        checkOutput("t2_abort_mux",   bus.mux_ctrl,   0);
        checkOutput("t2_abort_done",  bus.scan_done,  0);
        checkOutput("t2_abort_valid", bus.samp_valid, 0);
        @(negedge dsp_clkout);
        checkOutput("t2_abort_no_done_late", bus.scan_done, 0);

        // Back-pressure: hold samp_ready low for 20 cycles
        adcDataBase    = 16'hA5C1;
        bus.samp_ready = 1'b0;
        applyStimulus(4'b0100, 1'b0);
        waitValid("t3_valid", 40);
        checkOutput("t3_samp_data", bus.samp_data, 32'hA5C3);
        checkOutput("t3_samp_ch",   bus.samp_ch,   2);
        stableOk = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge dsp_clkout);
            if (bus.samp_valid !== 1'b1 || bus.samp_data !== 16'hA5C3 ||
                bus.samp_ch !== 2'd2 || bus.adc_conv !== 1'b0) stableOk = 1'b0;
        end
        checkOutput("t3_hold_stable", {31'b0, stableOk}, 1);
        bus.samp_ready = 1'b1;
        @(negedge dsp_clkout);
        checkOutput("t3_valid_after_hs", bus.samp_valid, 0);
        checkOutput("t3_done_after_hs",  bus.scan_done,  1);

        // Start with an empty mask is ignored
        applyStimulus(4'b0000, 1'b0);
        checkOutput("t4a_busy", bus.scan_busy, 0);
        @(negedge dsp_clkout);
        checkOutput("t4a_mux",  bus.mux_ctrl,  0);
        checkOutput("t4a_done", bus.scan_done, 0);

        // Start together with abort stays idle
        @(negedge dsp_clkout);
        bus.ch_mask    = 4'b1111;
        bus.scan_start = 1'b1;
        bus.scan_abort = 1'b1;
        @(negedge dsp_clkout);
        bus.scan_start = 1'b0;
        bus.scan_abort = 1'b0;
        checkOutput("t4b_busy", bus.scan_busy, 0);
        @(negedge dsp_clkout);
        checkOutput("t4b_mux",  bus.mux_ctrl,  0);

        // Start while busy is ignored; mask and mode stay latched
        adcDataBase = 16'h3300;
        applyStimulus(4'b0001, 1'b0);
        @(negedge dsp_clkout);
        bus.ch_mask    = 4'b1000;
        bus.continuous = 1'b1;
        bus.scan_start = 1'b1;
        @(negedge dsp_clkout);
        bus.scan_start = 1'b0;
        checkOutput("t4c_still_busy", bus.scan_busy, 1);
        waitValid("t4c_valid", 40);
        checkOutput("t4c_samp_ch",   bus.samp_ch,   0);
        checkOutput("t4c_samp_data", bus.samp_data, 32'h3300);
        @(negedge dsp_clkout);
        checkOutput("t4c_done", bus.scan_done, 1);
        checkOutput("t4c_idle", bus.scan_busy, 0);

        // ADC never responds
        adcMode = 1;
        applyStimulus(4'b0001, 1'b0);
        waitConv("t5_conv", 40);
`ifdef ADC_SCAN_TIMEOUT_EN
        repeat (15) @(negedge dsp_clkout);
        checkOutput("t5_err_not_early", bus.conv_err,  0);
        checkOutput("t5_busy_waiting",  bus.scan_busy, 1);
        @(negedge dsp_clkout);
        checkOutput("t5_err_set",   bus.conv_err,  1);
        checkOutput("t5_err_idle",  bus.scan_busy, 0);
        checkOutput("t5_err_mux",   bus.mux_ctrl,  0);
        checkOutput("t5_err_nodone", bus.scan_done, 0);
        @(negedge dsp_clkout);
        checkOutput("t5_err_sticky", bus.conv_err, 1);
        adcMode = 0;
        applyStimulus(4'b0001, 1'b0);
        checkOutput("t5_err_cleared", bus.conv_err, 0);
`else
        repeat (30) @(negedge dsp_clkout);
        checkOutput("t5_no_err",       bus.conv_err,  0);
        checkOutput("t5_still_waiting", bus.scan_busy, 1);
        adcMode = 0;
`endif
        bus.scan_abort = 1'b1;
        @(negedge dsp_clkout);
        bus.scan_abort = 1'b0;
        checkOutput("t5_abort_idle", bus.scan_busy, 0);

        // Reset during SETTLE clears everything asynchronously
        applyStimulus(4'b0100, 1'b0);
        @(negedge dsp_clkout);
        checkOutput("t6_choice_pre", bus.adc_data_choice, 2);
        checkOutput("t6_mux_pre",    bus.mux_ctrl,        1);
        @(negedge dsp_clkout);
        reset = 1'b1;
        #1;
        checkOutput("t6_mux",    bus.mux_ctrl,        0);
        checkOutput("t6_choice", bus.adc_data_choice, 0);
        checkOutput("t6_busy",   bus.scan_busy,       0);
        checkOutput("t6_data",   bus.samp_data,       0);
        checkOutput("t6_valid",  bus.samp_valid,      0);
        @(negedge dsp_clkout);
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
